fir_output_requantizer: RTL and testbench

- Downstream stage of the L=3 parallel/pipelined FIR. Consumes the filter's 32-bit full-precision output.
- Discards the pipeline warm-up samples after reset, then rounds and saturates each sample to 16 bits.
- Optionally decimates the stream and buffers it in a small FIFO with a valid/ready master interface towards the DAC or capture logic.
- Reports saturation and FIFO-overflow statistics.

---
 rtl/fir_output_requantizer_if.sv | 11 +
 rtl/fir_output_requantizer.sv | 177 +++++++++++++++++
 tb/tb_fir_output_requantizer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_output_requantizer_if.sv
// Output stream of the FIR requantizer: FIFO head word with valid/ready handshake.
interface fir_output_requantizer_if #(
  parameter int OUT_W = 16
) ();
  logic             m_valid;
  logic             m_ready;
  logic [OUT_W-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fir_output_requantizer.sv
// Drops FIR warm-up samples, then rounds, saturates, optionally decimates and
// buffers the stream in a small FIFO with overflow and saturation statistics.
module fir_output_requantizer #(
  parameter int IN_W   = 32,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 15,
  parameter int WARMUP = 4,
  parameter int DECIM  = 1,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [IN_W-1:0]          din,
  input  logic                     clear_stats,
  fir_output_requantizer_if.master m,
  output logic                     sat_flag,
  output logic [15:0]              ovf_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic signed [IN_W:0] ROUND = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [IN_W:0] MAX_V = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] MAX_W = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_W = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic {WARM, RUN} state_t;

  state_t state, state_next;
  logic [31:0] warm_cnt;
  logic        warm_last;
  logic        warm_advance;
  logic        run_sample;

  assign warm_last = (warm_cnt == 32'(WARMUP - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= (WARMUP == 0) ? RUN : WARM;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WARM:    if (in_valid && warm_last) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = WARM;
    endcase
  end

  always_comb begin
    warm_advance = 1'b0;
    run_sample   = 1'b0;
    case (state)
      WARM:    warm_advance = in_valid;
      RUN:     run_sample   = in_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             warm_cnt <= '0;
    else if (warm_advance) warm_cnt <= warm_cnt + 32'd1;
  end

  // Phase 0 is kept, so the first sample after warm-up always survives.
  logic [31:0] phase;
  logic        keep;

  assign keep = run_sample && (phase == 32'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           phase <= '0;
    else if (run_sample) phase <= (phase == 32'(DECIM - 1)) ? 32'd0 : phase + 32'd1;
  end

  // One extra bit keeps the half-up rounding add from wrapping.
  logic signed [IN_W:0] din_ext;
  logic signed [IN_W:0] round_sum;
  logic signed [IN_W:0] r_shift;
  logic signed [IN_W:0] r1;
  logic                 v1;

  assign din_ext   = signed'({din[IN_W-1], din});
  assign round_sum = din_ext + ROUND;
  assign r_shift   = round_sum >>> SHIFT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0;
      r1 <= '0;
    end else begin
      v1 <= keep;
      if (keep) r1 <= r_shift;
    end
  end

  logic             sat_hi;
  logic             sat_lo;
  logic             sat_event;
  logic [OUT_W-1:0] sat_word;
  logic [OUT_W-1:0] d2;
  logic             v2;

  assign sat_hi    = (r1 > MAX_V);
  assign sat_lo    = (r1 < MIN_V);
  assign sat_event = v1 && (sat_hi || sat_lo);
  assign sat_word  = sat_hi ? MAX_W : (sat_lo ? MIN_W : r1[OUT_W-1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2 <= 1'b0;
      d2 <= '0;
    end else begin
      v2 <= v1;
      if (v1) d2 <= sat_word;
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  assign full      = (fifo_level == FULL_LEVEL);
  assign m.m_valid = (fifo_level != '0);
  assign m.m_data  = m.m_valid ? mem[rd_ptr] : '0;
  assign pop       = m.m_valid && m.m_ready;
  assign push      = v2 && (!full || pop);
  assign drop      = v2 && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= d2;
  end

  // A fresh event on the clearing edge takes priority over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_flag  <= 1'b0;
      ovf_count <= '0;
    end else begin
      if (sat_event)        sat_flag <= 1'b1;
      else if (clear_stats) sat_flag <= 1'b0;

      if (drop) begin
        if (clear_stats)                ovf_count <= 16'd1;
        else if (ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
      end else if (clear_stats) begin
        ovf_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fir_output_requantizer.sv
// Scoreboard bench: stimulus pushes hand-computed words, negedge monitors pop and compare.
module tb_fir_output_requantizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid_a;
  logic        in_valid_b;
  logic        clear_stats;
  logic [31:0] din;
  logic        sat_flag_a, sat_flag_b;
  logic [15:0] ovf_count_a, ovf_count_b;
  logic [3:0]  fifo_level_a, fifo_level_b;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  logic [15:0] head_a, head_b;

  always #5 clk = ~clk;

  fir_output_requantizer_if #(.OUT_W(16)) bus_a ();
  fir_output_requantizer_if #(.OUT_W(16)) bus_b ();

  fir_output_requantizer dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .din(din),
    .clear_stats(clear_stats), .m(bus_a.master), .sat_flag(sat_flag_a),
    .ovf_count(ovf_count_a), .fifo_level(fifo_level_a)
  );

  fir_output_requantizer #(.DECIM(3)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .din(din),
    .clear_stats(clear_stats), .m(bus_b.master), .sat_flag(sat_flag_b),
    .ovf_count(ovf_count_b), .fifo_level(fifo_level_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] value, input bit to_b, input bit keep,
                               input logic [15:0] expected);
    din = value;
    if (to_b) in_valid_b = 1'b1;
    else      in_valid_a = 1'b1;
    if (keep) begin
      if (to_b) exp_b.push_back(expected);
      else      exp_a.push_back(expected);
    end
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input int budget);
    int c = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    checkOutput("drain_pending", 32'(exp_a.size() + exp_b.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (bus_a.m_valid && bus_a.m_ready) begin
      if (exp_a.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL a_spurious actual=0x%0h required=none", bus_a.m_data);
      end else begin
        head_a = exp_a.pop_front();
        checkOutput("a_data", 32'(bus_a.m_data), 32'(head_a));
      end
    end
  end

  always @(negedge clk) begin
    if (bus_b.m_valid && bus_b.m_ready) begin
      if (exp_b.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL b_spurious actual=0x%0h required=none", bus_b.m_data);
      end else begin
        head_b = exp_b.pop_front();
        checkOutput("b_data", 32'(bus_b.m_data), 32'(head_b));
      end
    end
  end

  initial begin
    reset         = 1'b1;
    in_valid_a    = 1'b0;
    in_valid_b    = 1'b0;
    clear_stats   = 1'b0;
    din           = '0;
    bus_a.m_ready = 1'b1;
    bus_b.m_ready = 1'b1;

    #12;
    checkOutput("reset_m_valid", 32'(bus_a.m_valid), 32'd0);
    checkOutput("reset_m_data", 32'(bus_a.m_data), 32'd0);
    checkOutput("reset_sat_flag", 32'(sat_flag_a), 32'd0);
    checkOutput("reset_ovf_count", 32'(ovf_count_a), 32'd0);
    checkOutput("reset_fifo_level", 32'(fifo_level_a), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] warm-up drop");
    for (int k = 1; k <= 6; k++) applyStimulus(32'(k) << 15, 1'b0, k >= 5, 16'(k));
    idle(4);

    $display("[TB] rounding");
    applyStimulus(32'h0000_4000, 1'b0, 1'b1, 16'h0001);
    applyStimulus(32'h0000_3FFF, 1'b0, 1'b1, 16'h0000);
    applyStimulus(32'hFFFF_C000, 1'b0, 1'b1, 16'h0000);
    applyStimulus(32'hFFFF_BFFF, 1'b0, 1'b1, 16'hFFFF);
    idle(4);
    checkOutput("round_sat_flag", 32'(sat_flag_a), 32'd0);

    $display("[TB] saturation");
    applyStimulus(32'h4000_0000, 1'b0, 1'b1, 16'h7FFF);
    applyStimulus(32'hBFFF_0000, 1'b0, 1'b1, 16'h8000);
    applyStimulus(32'hC000_0000, 1'b0, 1'b1, 16'h8000);
    idle(4);
    checkOutput("sat_flag_set", 32'(sat_flag_a), 32'd1);
    clear_stats = 1'b1;
    idle(1);
    clear_stats = 1'b0;
    checkOutput("sat_flag_cleared", 32'(sat_flag_a), 32'd0);
    checkOutput("ovf_cleared", 32'(ovf_count_a), 32'd0);

    applyStimulus(32'h4000_0000, 1'b0, 1'b1, 16'h7FFF);
    clear_stats = 1'b1;
    idle(1);
    clear_stats = 1'b0;
    checkOutput("clear_vs_sat_event", 32'(sat_flag_a), 32'd1);
    clear_stats = 1'b1;
    idle(1);
    clear_stats = 1'b0;
    checkOutput("sat_flag_recleared", 32'(sat_flag_a), 32'd0);
    idle(4);

    $display("[TB] decimation");
    for (int i = 0; i < 4; i++) applyStimulus(32'h0000_8000, 1'b1, 1'b0, 16'h0000);
    for (int k = 10; k <= 18; k++) applyStimulus(32'(k) << 15, 1'b1, ((k - 10) % 3) == 0, 16'(k));
    idle(4);
    checkOutput("decim_drained", 32'(exp_b.size()), 32'd0);

    $display("[TB] overflow and backpressure");
    bus_a.m_ready = 1'b0;
    for (int k = 20; k <= 31; k++) applyStimulus(32'(k) << 15, 1'b0, k < 28, 16'(k));
    idle(3);
    checkOutput("ovf_fifo_level", 32'(fifo_level_a), 32'd8);
    checkOutput("ovf_count", 32'(ovf_count_a), 32'd4);
    checkOutput("ovf_m_valid", 32'(bus_a.m_valid), 32'd1);

    $display("[TB] full with simultaneous pop");
    applyStimulus(32'(40) << 15, 1'b0, 1'b1, 16'd40);
    checkOutput("full_pop_level_40", 32'(fifo_level_a), 32'd8);
    applyStimulus(32'(41) << 15, 1'b0, 1'b1, 16'd41);
    checkOutput("full_pop_level_41", 32'(fifo_level_a), 32'd8);
    bus_a.m_ready = 1'b1;
    for (int k = 42; k <= 45; k++) begin
      applyStimulus(32'(k) << 15, 1'b0, 1'b1, 16'(k));
      checkOutput("full_pop_level", 32'(fifo_level_a), 32'd8);
    end
    idle(2);
    checkOutput("full_pop_tail_level", 32'(fifo_level_a), 32'd8);
    checkOutput("full_pop_ovf_count", 32'(ovf_count_a), 32'd4);
    waitDrain(60);
    checkOutput("drained_level", 32'(fifo_level_a), 32'd0);
    checkOutput("drained_m_valid", 32'(bus_a.m_valid), 32'd0);
    checkOutput("empty_m_data", 32'(bus_a.m_data), 32'd0);
    idle(2);
    checkOutput("empty_ready_level", 32'(fifo_level_a), 32'd0);

    $display("[TB] mid-stream reset");
    bus_a.m_ready = 1'b0;
    for (int k = 50; k <= 54; k++) applyStimulus(32'(k) << 15, 1'b0, 1'b0, 16'h0000);
    checkOutput("pre_reset_level", 32'(fifo_level_a), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_m_valid", 32'(bus_a.m_valid), 32'd0);
    checkOutput("async_reset_level", 32'(fifo_level_a), 32'd0);
    checkOutput("async_reset_ovf", 32'(ovf_count_a), 32'd0);
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus_a.m_ready = 1'b1;
    for (int k = 1; k <= 6; k++) applyStimulus(32'(k) << 15, 1'b0, k >= 5, 16'(k));
    waitDrain(40);
    checkOutput("final_level", 32'(fifo_level_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
